// File: rtl/pc_trace_unit.sv
// Cycle/PC trace tap: counts enabled cycles, samples the CPU PC every SAMPLE_PERIOD
// cycles into a small first-word-fall-through FIFO that drains over valid/ready.
module pc_trace_unit #(
  parameter int SAMPLE_PERIOD = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [31:0]                   pc_in,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [CNT_W-1:0]              trace_cycle,
  output logic [31:0]                   trace_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(SAMPLE_PERIOD - 1);
  localparam logic [AW:0]   DEPTH      = (AW+1)'(FIFO_DEPTH);

  logic [CNT_W-1:0] cycle_reg;
  logic [CNT_W-1:0] cycle_next;
  logic [PW-1:0]    period_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [15:0]      drop_reg;

  logic [CNT_W-1:0] mem_cycle [FIFO_DEPTH];
  logic [31:0]      mem_pc    [FIFO_DEPTH];

  logic sample;
  logic full;
  logic pop;
  logic push;

  assign cycle_next = cycle_reg + CNT_W'(1);
  assign sample     = en && (period_reg == LAST_PHASE);
  assign full       = (level_reg == DEPTH);
  assign pop        = trace_valid && trace_ready;
  // A full FIFO still takes the sample when the head leaves on the same edge.
  assign push       = sample && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_reg  <= '0;
      period_reg <= '0;
    end else if (en) begin
      cycle_reg  <= cycle_next;
      period_reg <= (period_reg == LAST_PHASE) ? '0 : period_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      drop_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        level_reg <= level_reg + (AW+1)'(1);
      end else if (pop && !push) begin
        level_reg <= level_reg - (AW+1)'(1);
      end
      if (sample && !push && (drop_reg != 16'hFFFF)) begin
        drop_reg <= drop_reg + 16'd1;
      end
    end
  end

  // Storage has no reset; stale slots are hidden by the level/pointer state.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_cycle[wr_ptr_reg] <= cycle_next;
      mem_pc[wr_ptr_reg]    <= pc_in;
    end
  end

  assign trace_valid = (level_reg != '0);
  assign trace_cycle = trace_valid ? mem_cycle[rd_ptr_reg] : '0;
  assign trace_pc    = trace_valid ? mem_pc[rd_ptr_reg] : '0;
  assign fifo_level  = level_reg;
  assign drop_cnt    = drop_reg;

endmodule

// File: tb/tb_pc_trace_unit.sv
// Scoreboard bench for pc_trace_unit: directed phases push hand-computed records,
// independent monitors compare every handshake against the queues.
module tb_pc_trace_unit;

  localparam logic [31:0] PC_BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst2 = 1'b0;
  logic        en = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_ready2 = 1'b1;
  logic [31:0] pc_in = PC_BASE + 32'd4;

  logic        valid1;
  logic [31:0] cycle1;
  logic [31:0] pc1;
  logic [2:0]  level1;
  logic [15:0] drop1;

  logic        valid2;
  logic [3:0]  cycle2;
  logic [31:0] pc2;
  logic [2:0]  level2;
  logic [15:0] drop2;

  always #5 clk = ~clk;

  pc_trace_unit #(.SAMPLE_PERIOD(10), .FIFO_DEPTH(4), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .en(en), .pc_in(pc_in),
    .trace_valid(valid1), .trace_ready(trace_ready),
    .trace_cycle(cycle1), .trace_pc(pc1),
    .fifo_level(level1), .drop_cnt(drop1)
  );

  pc_trace_unit #(.SAMPLE_PERIOD(5), .FIFO_DEPTH(4), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst2), .en(en), .pc_in(pc_in),
    .trace_valid(valid2), .trace_ready(trace_ready2),
    .trace_cycle(cycle2), .trace_pc(pc2),
    .fifo_level(level2), .drop_cnt(drop2)
  );

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
  } rec_t;

  rec_t q1[$];
  rec_t q2[$];
  int   errors = 0;
  int   checks = 0;
  int   ecyc = 0;

  function automatic logic [31:0] pcx(int c);
    return PC_BASE + 32'(4 * c);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic exp1(int c);
    q1.push_back('{cyc: 32'(c), pc: pcx(c)});
  endtask

  task automatic exp2(int wrapped, int c);
    q2.push_back('{cyc: 32'(wrapped), pc: pcx(c)});
  endtask

  // pc_in always carries the PC belonging to the cycle number the next enabled edge records.
  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) ecyc = 0;
      else if (en) ecyc++;
      #1;
      pc_in = pcx(ecyc + 1);
    end
  endtask

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst && valid1 && trace_ready) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u1_unexpected: got record cycle=%0d pc=0x%h, expected none", cycle1, pc1);
        end else begin
          r = q1.pop_front();
          $display("u1 record cycle=%0d pc=0x%h (expect %0d 0x%h)", cycle1, pc1, r.cyc, r.pc);
          check("u1_cycle", cycle1, r.cyc);
          check("u1_pc", pc1, r.pc);
        end
      end
    end
  end

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst2 && valid2 && trace_ready2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u2_unexpected: got record cycle=%0d pc=0x%h, expected none", cycle2, pc2);
        end else begin
          r = q2.pop_front();
          $display("u2 record cycle=%0d pc=0x%h (expect %0d 0x%h)", cycle2, pc2, r.cyc, r.pc);
          check("u2_cycle", 32'(cycle2), r.cyc);
          check("u2_pc", pc2, r.pc);
        end
      end
    end
  end

  initial begin
    // Phase 1: reset then free-running trace
    tick(10);
    check("rst_valid", 32'(valid1), 0);
    check("rst_level", 32'(level1), 0);
    check("rst_drop", 32'(drop1), 0);
    check("rst_cycle", cycle1, 0);
    check("rst_pc", pc1, 0);
    rst = 1'b1; en = 1'b1; trace_ready = 1'b1;
    exp1(10); exp1(20);
    tick(9);
    check("p1_no_early_valid", 32'(valid1), 0);
    tick(1);
    check("p1_first_valid", 32'(valid1), 1);
    check("p1_first_cycle", cycle1, 10);
    tick(11);

    // Phase 2: backpressure fills the FIFO, later samples are dropped
    trace_ready = 1'b0; rst = 1'b0;
    tick(1);
    rst = 1'b1;
    exp1(10); exp1(20); exp1(30); exp1(40);
    tick(10);
    for (int i = 0; i < 50; i++) begin
      check("p2_hold_cycle", cycle1, 10);
      check("p2_hold_pc", pc1, pcx(10));
      tick(1);
    end
    check("p2_level", 32'(level1), 4);
    check("p2_drop", 32'(drop1), 2);
    check("p2_valid", 32'(valid1), 1);

    // Phase 3: pop and push on the same edge while full
    tick(9);
    trace_ready = 1'b1;
    exp1(70);
    tick(1);
    trace_ready = 1'b0;
    check("p3_level", 32'(level1), 4);
    check("p3_drop", 32'(drop1), 2);
    check("p3_head_cycle", cycle1, 20);
    check("p3_head_pc", pc1, pcx(20));
    trace_ready = 1'b1;
    tick(5);
    check("p3_drained_level", 32'(level1), 0);
    check("p3_drained_valid", 32'(valid1), 0);

    // Phase 4: enable gating holds the phase
    rst = 1'b0;
    tick(1);
    check("p4_rst_drop", 32'(drop1), 0);
    check("p4_rst_level", 32'(level1), 0);
    rst = 1'b1;
    exp1(10); exp1(20);
    tick(15);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("p4_gap_valid", 32'(valid1), 0);
    end
    en = 1'b1;
    tick(4);
    check("p4_pre_valid", 32'(valid1), 0);
    tick(1);
    check("p4_resume_valid", 32'(valid1), 1);
    check("p4_resume_cycle", cycle1, 20);
    tick(1);

    // Phase 5: reset while records are queued
    trace_ready = 1'b0; rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(30);
    check("p5_level_before", 32'(level1), 3);
    rst = 1'b0;
    tick(1);
    check("p5_valid", 32'(valid1), 0);
    check("p5_level", 32'(level1), 0);
    check("p5_drop", 32'(drop1), 0);
    check("p5_cycle", cycle1, 0);
    rst = 1'b1; trace_ready = 1'b1;
    exp1(10);
    tick(10);
    check("p5_next_cycle", cycle1, 10);
    tick(1);

    // Phase 6: narrow cycle counter wraps without disturbing period spacing
    rst = 1'b0;
    tick(1);
    check("p6_u2_rst_valid", 32'(valid2), 0);
    check("p6_u2_rst_level", 32'(level2), 0);
    rst = 1'b1; rst2 = 1'b1;
    exp1(10); exp1(20);
    exp2(5, 5); exp2(10, 10); exp2(15, 15); exp2(4, 20); exp2(9, 25);
    tick(26);
    check("u2_drop", 32'(drop2), 0);
    check("q1_drained", 32'(q1.size()), 0);
    check("q2_drained", 32'(q2.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
